simon_sequencer: RTL and testbench

Game-sequence engine for the Simon Says design, sitting directly upstream of `tlt_blinker`. Generates a pseudo-random colour sequence with an 8-bit LFSR, replays the first `round` entries one blink at a time through a valid/ready/done handshake to the blinker, then checks debounced player key pulses against the same sequence. Each correct round grows the sequence by one entry; it finishes with win at `MAX_LEN` or fail on a wrong key or timeout.

---
 rtl/simon_pkg.sv | 24 ++
 rtl/simon_lfsr8.sv | 29 ++
 rtl/simon_sequencer.sv | 148 ++++++++++++++
 tb/tb_simon_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and the LFSR step function for the Simon game sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY_REQ,
    S_PLAY_WAIT,
    S_INPUT,
    S_GAP,
    S_WIN,
    S_FAIL
  } simon_state_t;

  typedef logic [1:0] colour_t;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [3:0] colour_onehot(input colour_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_lfsr8.sv
// 8-bit Fibonacci LFSR holding the colour sequence; the low two bits are the
// current colour. Load takes priority over step.
module simon_lfsr8
  import simon_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic    clk_sys,
  input  logic    reset,
  input  logic    load,
  input  logic    step,
  output colour_t colour
);

  logic [7:0] state;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= '0;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= lfsr8_next(state);
    end
  end

  assign colour = state[1:0];

endmodule

// File: rtl/simon_sequencer.sv
// Simon game-sequence engine: replays the first `round` LFSR colours to the
// blinker, then checks player keys against the same sequence.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         GAP_CYC     = 25_000_000,
  parameter int         TIMEOUT_CYC = 250_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn_pulse,
  output logic       blink_valid,
  output logic [1:0] blink_colour,
  input  logic       blink_ready,
  input  logic       blink_done,
  output logic [4:0] round,
  output logic       await_input,
  output logic       win,
  output logic       fail
);

  // state       | meaning
  // S_IDLE      | no game since reset, waiting for start
  // S_PLAY_REQ  | blink request held until blinker accepts
  // S_PLAY_WAIT | blink in progress, waiting for blink_done
  // S_INPUT     | checking player keys, timeout running
  // S_GAP       | pause between a completed pass and the next replay
  // S_WIN       | sequence of MAX_LEN entered correctly
  // S_FAIL      | wrong key or timeout

  localparam int T_MAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TW-1:0] GAP_LOAD     = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [4:0]    LAST_ROUND   = 5'(MAX_LEN);

  simon_state_t    state_q, state_nxt;
  logic [4:0]      step_q, step_nxt;
  logic [4:0]      round_nxt;
  logic [TW-1:0]   timer_q, timer_nxt;
  logic            lfsr_load, lfsr_step;
  colour_t         cur_colour;
  logic            last_step;

  simon_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk_sys (CLOCK_50),
    .reset   (reset),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .colour  (cur_colour)
  );

  assign blink_colour = cur_colour;
  assign last_step    = (step_q == round - 5'd1);

  always_comb begin
    state_nxt = state_q;
    step_nxt  = step_q;
    round_nxt = round;
    timer_nxt = timer_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      S_IDLE, S_WIN, S_FAIL: begin
        if (start) begin
          round_nxt = 5'd1;
          step_nxt  = '0;
          lfsr_load = 1'b1;
          state_nxt = S_PLAY_REQ;
        end
      end
      S_PLAY_REQ: begin
        if (blink_valid && blink_ready) state_nxt = S_PLAY_WAIT;
      end
      S_PLAY_WAIT: begin
        if (blink_done) begin
          if (last_step) begin
            lfsr_load = 1'b1;
            step_nxt  = '0;
            timer_nxt = TIMEOUT_LOAD;
            state_nxt = S_INPUT;
          end else begin
            lfsr_step = 1'b1;
            step_nxt  = step_q + 5'd1;
            state_nxt = S_PLAY_REQ;
          end
        end
      end
      S_INPUT: begin
        // A key in the terminal-count cycle still counts; it is checked first.
        if (btn_pulse != 4'b0000) begin
          if (btn_pulse == colour_onehot(cur_colour)) begin
            timer_nxt = TIMEOUT_LOAD;
            if (!last_step) begin
              lfsr_step = 1'b1;
              step_nxt  = step_q + 5'd1;
            end else if (round == LAST_ROUND) begin
              state_nxt = S_WIN;
            end else begin
              round_nxt = round + 5'd1;
              lfsr_load = 1'b1;
              step_nxt  = '0;
              timer_nxt = GAP_LOAD;
              state_nxt = S_GAP;
            end
          end else begin
            state_nxt = S_FAIL;
          end
        end else if (timer_q == '0) begin
          state_nxt = S_FAIL;
        end else begin
          timer_nxt = timer_q - TW'(1);
        end
      end
      S_GAP: begin
        if (timer_q == '0) state_nxt = S_PLAY_REQ;
        else               timer_nxt = timer_q - TW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      timer_q     <= '0;
      round       <= '0;
      blink_valid <= 1'b0;
      await_input <= 1'b0;
      win         <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      step_q      <= step_nxt;
      timer_q     <= timer_nxt;
      round       <= round_nxt;
      blink_valid <= (state_nxt == S_PLAY_REQ);
      await_input <= (state_nxt == S_INPUT);
      win         <= (state_nxt == S_WIN);
      fail        <= (state_nxt == S_FAIL);
    end
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: blinker model, directed games, then random games
// checked against a sequence/round model.
module tb_simon_sequencer;

  localparam int         MAX_LEN     = 3;
  localparam int         GAP_CYC     = 4;
  localparam int         TIMEOUT_CYC = 20;
  localparam logic [7:0] SEED        = 8'hA5;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] btn_pulse;
  logic       blink_valid;
  logic [1:0] blink_colour;
  logic       blink_ready;
  logic       blink_done;
  logic [4:0] round;
  logic       await_input;
  logic       win;
  logic       fail;

  int checks   = 0;
  int failures = 0;

  logic [1:0] seq [MAX_LEN];
  logic [1:0] played [$];
  int         base = 0;
  int         flush_req = 0;
  bit         rand_mode = 0;

  typedef struct {
    int         d;
    logic [3:0] key;
  } act_t;
  act_t plan [$];

  simon_sequencer #(
    .MAX_LEN     (MAX_LEN),
    .SEED        (SEED),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .start        (start),
    .btn_pulse    (btn_pulse),
    .blink_valid  (blink_valid),
    .blink_colour (blink_colour),
    .blink_ready  (blink_ready),
    .blink_done   (blink_done),
    .round        (round),
    .await_input  (await_input),
    .win          (win),
    .fail         (fail)
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_next(input logic [7:0] l);
    logic [7:0] n;
    n    = l << 1;
    n[0] = l[7] ^ l[5] ^ l[4] ^ l[3];
    return n;
  endfunction

  // Blinker: ready when idle, done pulse 5 cycles after the accepting edge.
  initial begin
    int cnt;
    int flush_seen;
    cnt = 0;
    flush_seen = 0;
    blink_ready = 1'b1;
    blink_done  = 1'b0;
    forever begin
      @(posedge CLOCK_50);
      #1;
      blink_done = 1'b0;
      if (flush_seen != flush_req) begin
        flush_seen  = flush_req;
        cnt         = 0;
        blink_ready = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          blink_done  = 1'b1;
          blink_ready = 1'b1;
        end else begin
          blink_ready = 1'b0;
        end
      end else if (blink_valid && blink_ready && !reset) begin
        played.push_back(blink_colour);
        cnt = 5;
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic noise();
    start     = ($urandom_range(0, 5) == 0);
    btn_pulse = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
  endtask

  task automatic add_act(input int d, input logic [3:0] key);
    act_t a;
    a.d   = d;
    a.key = key;
    plan.push_back(a);
  endtask

  task automatic wait_input(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      bit done_now;
      if (rand_mode) noise();
      done_now = blink_done;
      tick();
      start     = 1'b0;
      btn_pulse = 4'b0000;
      if (done_now) check("done_to_next", 32'(blink_valid | await_input), 1);
      if (await_input) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("await_timeout", 32'(await_input), 1);
  endtask

  // res: 0 next round, 1 win, 2 fail, 3 aborted
  task automatic do_pass(input int r, output int res);
    bit ok;
    int got_n;
    res = 3;
    wait_input(ok);
    if (!ok) return;
    got_n = played.size() - base;
    check("replay_len", got_n, r);
    for (int i = 0; i < r && i < got_n; i++)
      check($sformatf("replay_colour[%0d]", i), 32'(played[base+i]), 32'(seq[i]));
    check("replay_round", 32'(round), r);
    for (int j = 0; j < r; j++) begin
      int d;
      logic [3:0] good, key;
      good = 4'b0001 << seq[j];
      if (plan.size() > 0) begin
        act_t a;
        a   = plan.pop_front();
        d   = a.d;
        key = (a.key == 4'b0000) ? good : a.key;
      end else if (rand_mode) begin
        int p;
        p = $urandom_range(0, 99);
        if (p < 6)       d = TIMEOUT_CYC + $urandom_range(0, 2);
        else if (p < 12) d = TIMEOUT_CYC - 1;
        else             d = $urandom_range(0, 3);
        key = good;
        if ($urandom_range(0, 99) < 7) begin
          key = 4'($urandom_range(1, 15));
          if (key == good) key = good ^ 4'hF;
        end
      end else begin
        d   = 0;
        key = good;
      end
      for (int t = 1; t <= d && t <= TIMEOUT_CYC; t++) begin
        if (rand_mode) start = ($urandom_range(0, 7) == 0);
        tick();
        start = 1'b0;
        check("idle_fail", 32'(fail), 32'(t >= TIMEOUT_CYC));
      end
      if (d >= TIMEOUT_CYC) begin
        check("timeout_await", 32'(await_input), 0);
        check("timeout_round", 32'(round), r);
        res = 2;
        return;
      end
      btn_pulse = key;
      tick();
      btn_pulse = 4'b0000;
      if (key != good) begin
        check("wrong_fail", 32'(fail), 1);
        check("wrong_await", 32'(await_input), 0);
        btn_pulse = good;
        tick();
        btn_pulse = 4'b0000;
        check("post_fail_hold", 32'(fail), 1);
        check("post_fail_await", 32'(await_input), 0);
        check("post_fail_round", 32'(round), r);
        res = 2;
        return;
      end
      check("key_fail", 32'(fail), 0);
      if (j < r - 1) begin
        check("key_await", 32'(await_input), 1);
      end else if (r == MAX_LEN) begin
        check("win_flag", 32'(win), 1);
        check("win_round", 32'(round), MAX_LEN);
        check("win_await", 32'(await_input), 0);
        res = 1;
        return;
      end else begin
        int gap;
        bit seen;
        base = played.size();
        check("gap_round", 32'(round), r + 1);
        check("gap_await", 32'(await_input), 0);
        check("gap_valid", 32'(blink_valid), 0);
        gap  = 0;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
          if (rand_mode) noise();
          tick();
          start     = 1'b0;
          btn_pulse = 4'b0000;
          gap++;
          if (blink_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("gap_len", gap, GAP_CYC);
        if (!seen) return;
        res = 0;
      end
    end
  endtask

  task automatic play_game(output int res);
    res  = 3;
    base = played.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_valid", 32'(blink_valid), 1);
    check("start_colour", 32'(blink_colour), 32'(seq[0]));
    check("start_round", 32'(round), 1);
    check("start_win", 32'(win), 0);
    check("start_fail", 32'(fail), 0);
    for (int r = 1; r <= MAX_LEN; r++) begin
      do_pass(r, res);
      if (res != 0) break;
    end
  endtask

  initial begin
    int res;
    logic [7:0] l;
    reset     = 1'b1;
    start     = 1'b0;
    btn_pulse = 4'b0000;
    l = SEED;
    for (int i = 0; i < MAX_LEN; i++) begin
      seq[i] = l[1:0];
      l      = ref_next(l);
    end

    repeat (3) tick();
    check("rst_valid", 32'(blink_valid), 0);
    check("rst_colour", 32'(blink_colour), 0);
    check("rst_round", 32'(round), 0);
    check("rst_await", 32'(await_input), 0);
    check("rst_win", 32'(win), 0);
    check("rst_fail", 32'(fail), 0);
    reset = 1'b0;
    tick();

    // Full game, every key correct and immediate.
    play_game(res);
    check("gameA_result", res, 1);
    repeat (3) tick();
    check("win_sticky", 32'(win), 1);
    check("win_hold_round", 32'(round), MAX_LEN);

    // Round 2, second key 0001 while 0100 is expected.
    add_act(0, 4'b0000);
    add_act(0, 4'b0000);
    add_act(0, 4'b0001);
    play_game(res);
    check("gameB_result", res, 2);

    // Key on the last allowed cycle is accepted; next round times out.
    add_act(TIMEOUT_CYC - 1, 4'b0000);
    add_act(TIMEOUT_CYC, 4'b0000);
    play_game(res);
    check("gameC_result", res, 2);

    // Multi-bit key.
    add_act(0, 4'b0011);
    play_game(res);
    check("gameD_result", res, 2);
    check("gameD_round", 32'(round), 1);

    // Reset while a blink request is pending.
    base  = played.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("midrst_pre_valid", 32'(blink_valid), 1);
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(blink_valid), 0);
    check("midrst_round", 32'(round), 0);
    check("midrst_fail", 32'(fail), 0);
    tick();
    reset = 1'b0;
    flush_req++;
    btn_pulse = 4'b0010;
    tick();
    btn_pulse = 4'b0000;
    tick();
    check("idle_key_valid", 32'(blink_valid), 0);
    check("idle_key_round", 32'(round), 0);
    check("idle_key_fail", 32'(fail), 0);

    rand_mode = 1'b1;
    repeat (40) begin
      play_game(res);
      check("rand_game_end", 32'(res inside {1, 2}), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
